latch_write_sequencer: RTL and testbench
========================================

# latch_write_sequencer

- Shares one bank of clocked D latches between two requesters and produces glitch-free, sequenced writes.
- Arbitrates the two write requests round-robin and drives each latch's enable as a timed window: data setup, enable open, then data hold.
- Sits between requesting logic and the latch bank, so no requester toggles a latch's `D` or `clk` directly.

## Interface
- `WIDTH`, 8: latch data width.
- `NLATCH`, 4: number of latches in the bank; a power of two, 2..8.
- `AW`, $clog2(NLATCH): address width.
- `SETUP_CYC`, 1: cycles `lat_d` is stable before the enable opens; ≥1.
- `OPEN_CYC`, 2: cycles the enable is high; ≥1.
- `HOLD_CYC`, 1: cycles `lat_d` is stable after the enable closes; ≥1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  write requests; level, held until the matching grant.
- `addr0`, `addr1`  in  AW  target latch index of each requester.
- `data0`, `data1`  in  WIDTH  write data of each requester.
- `grant0`, `grant1`  out  1  one-cycle pulse; the request, address and data are captured on this cycle.
- `done0`, `done1`  out  1  one-cycle pulse in the final HOLD cycle of that requester's write.
- `busy`  out  1  high in every state except IDLE.
- `lat_d`  out  WIDTH  data bus to all latches.
- `lat_en`  out  NLATCH  per-latch enable; at most one bit high, and only in OPEN.

## Operation
- States: IDLE → SETUP → OPEN → HOLD → IDLE.
- IDLE: if any `req` is high, arbitrate in that cycle.
  - Pulse the winner's `grant`.
  - Register its `addr` into `cur_addr`, its `data` into `lat_d`, and the winner id into `owner`.
  - Go to SETUP.
  - If no request is high, stay in IDLE with all outputs idle.
- SETUP: stay `SETUP_CYC` cycles; `lat_en`=0; `lat_d` is held.
- OPEN: stay `OPEN_CYC` cycles; `lat_en` = one-hot(`cur_addr`), registered; `lat_d` is held.
- HOLD: stay `HOLD_CYC` cycles; `lat_en`=0; `lat_d` is held.
  - `done_owner`=1 in the last HOLD cycle only.
  - The next state is IDLE.
- A single down-counter, loaded on each state entry with the state length minus 1, times every phase. Its width is $clog2 of the maximum parameter, plus 1.
- Arbitration is round-robin using a `last` pointer, updated on every grant.
  - Both requests high: grant the requester that is not `last`.
  - Only one request high: grant it, whatever `last` holds.
- A request raised while `busy` is not granted until IDLE. It must stay high; the block does not queue it.
- `lat_d` keeps its last written value while IDLE, so the latch inputs do not toggle.
- Changes to `addrN`/`dataN` after the grant have no effect on the write in progress.
- Reset, at any time including mid-write:
  - state=IDLE, `lat_en`=0, `lat_d`=0, `busy`=0.
  - All `grant` and `done` pulses are 0; no `done` is issued for an aborted write.
  - `last`=1, so `req0` wins the first tie.

## Timing
- Reset values: every output is 0.
- Grant at edge k, counting the grant cycle as cycle k:
  - SETUP: cycles k+1 .. k+SETUP_CYC.
  - OPEN: the next `OPEN_CYC` cycles.
  - HOLD: the next `HOLD_CYC` cycles.
- Total occupancy is T = 1+SETUP_CYC+OPEN_CYC+HOLD_CYC cycles, from the grant to the IDLE re-entry, inclusive of the grant cycle.
  - `done` rises in cycle k+T-1.
  - The earliest next grant is in cycle k+T.
- With default parameters: T=5, and sustained throughput is one write per 5 cycles.
- `busy` is high from cycle k+1 through k+T-1.
- `lat_en` is high for exactly `OPEN_CYC` consecutive cycles per write.
  - It never changes in the same cycle as `lat_d`.
  - At least `SETUP_CYC` cycles of stable `lat_d` come before it rises, and at least `HOLD_CYC` after it falls.
- `grant` and `done` pulses never overlap for the same requester.

## Test plan
- Reset, then idle: `rst`=1 for 2 cycles, no requests → all outputs 0. With `req0`=1/`addr0`=2/`data0`=8'hA5:
  - `grant0` in the next IDLE cycle.
  - `lat_en`=4'b0100 for exactly 2 cycles, starting 2 cycles after the grant.
  - `lat_d`=8'hA5 throughout.
  - `done0` 4 cycles after the grant.
- Tie: `req0` and `req1` rise together and stay high → grants alternate 0,1,0,1 at 5-cycle spacing. `lat_en` bits follow each granted address.
- Late request: `req1` raised mid-write of requester 0 → `grant1` exactly in the cycle after `done0`. No `lat_en` overlap.
- Data churn: change `data0` every cycle after `grant0` → `lat_d` stays at the captured value until the next grant.
- Mid-write reset: assert `rst` for 1 cycle during OPEN:
  - `lat_en`=0 on the next edge.
  - No `done0`.
  - A tie afterwards → `grant0`.
- Parameter sweep: SETUP_CYC=3, OPEN_CYC=1, HOLD_CYC=2, NLATCH=8 → T=7. The enable is high for 1 cycle, 4 cycles after the grant. All `lat_en` one-hot checks pass.

Source files
------------

// File: rtl/latch_write_sequencer.sv
// Shares one bank of D latches between two requesters with round-robin
// arbitration and timed setup/open/hold enable windows.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req0/1            level write requests, held until the matching grant
//   addr0/1, data0/1  target latch index and write data of each requester
//   grant0/1          one-cycle pulse; request, address and data captured
//   done0/1           one-cycle pulse in the final HOLD cycle of a write
//   busy              high whenever a write is in progress
//   lat_d             data bus to all latches, held between writes
//   lat_en            per-latch enable, one-hot while the window is open
module latch_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int NLATCH    = 4,
  parameter int AW        = $clog2(NLATCH),
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic [WIDTH-1:0]  data0,
  input  logic [WIDTH-1:0]  data1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic [WIDTH-1:0]  lat_d,
  output logic [NLATCH-1:0] lat_en
);

  localparam int MAXP =
    (SETUP_CYC > OPEN_CYC)
      ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
      : ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SL = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OL = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HL = CW'(HOLD_CYC - 1);
  localparam logic [NLATCH-1:0] ONE = NLATCH'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [AW-1:0]     cur_addr, addr_n;
  logic [WIDTH-1:0]  d_n;
  logic [NLATCH-1:0] en_n;
  logic              owner, owner_n;
  logic              last, last_n;
  logic              win1;
  logic              g0, g1, dn0, dn1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = cur_addr;
    d_n     = lat_d;
    owner_n = owner;
    last_n  = last;
    en_n    = '0;
    win1    = 1'b0;
    g0      = 1'b0;
    g1      = 1'b0;
    dn0     = 1'b0;
    dn1     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst && (req0 || req1)) begin
          // On a tie the requester that was not served last wins
          win1    = req1 && (!req0 || !last);
          g0      = !win1;
          g1      = win1;
          owner_n = win1;
          last_n  = win1;
          addr_n  = win1 ? addr1 : addr0;
          d_n     = win1 ? data1 : data0;
          cnt_n   = SL;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = OPEN;
          cnt_n   = OL;
          en_n    = ONE << cur_addr;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HL;
        end else begin
          cnt_n = cnt - CW'(1);
          en_n  = lat_en;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          dn0     = !rst && !owner;
          dn1     = !rst && owner;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      lat_d    <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      lat_en   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_addr <= addr_n;
      lat_d    <= d_n;
      owner    <= owner_n;
      last     <= last_n;
      lat_en   <= en_n;
    end
  end

  assign grant0 = g0;
  assign grant1 = g1;
  assign done0  = dn0;
  assign done1  = dn1;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer: default build plus a
// second instance with a longer setup/hold and an eight-latch bank.
module tb_latch_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       grant0, grant1, done0, done1, busy;
  logic [7:0] lat_d;
  logic [3:0] lat_en;

  logic       b_req0, b_req1;
  logic [2:0] b_addr0, b_addr1;
  logic [7:0] b_data0, b_data1;
  logic       b_grant0, b_grant1, b_done0, b_done1, b_busy;
  logic [7:0] b_lat_d;
  logic [7:0] b_lat_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  latch_write_sequencer u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .grant0(grant0), .grant1(grant1),
    .done0(done0), .done1(done1),
    .busy(busy), .lat_d(lat_d), .lat_en(lat_en)
  );

  latch_write_sequencer #(
    .WIDTH(8), .NLATCH(8), .SETUP_CYC(3),
    .OPEN_CYC(1), .HOLD_CYC(2)
  ) u_sweep (
    .clk(clk), .rst(rst),
    .req0(b_req0), .req1(b_req1),
    .addr0(b_addr0), .addr1(b_addr1),
    .data0(b_data0), .data1(b_data1),
    .grant0(b_grant0), .grant1(b_grant1),
    .done0(b_done0), .done1(b_done1),
    .busy(b_busy), .lat_d(b_lat_d), .lat_en(b_lat_en)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1ns later.
  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0 = 0; req1 = 0;
    b_req0 = 0; b_req1 = 0;
    nxt(); nxt();
    rst = 1'b0;
  endtask

  logic [3:0] exp_en;
  logic       w1;

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0;
    addr0 = 0; addr1 = 0;
    data0 = 0; data1 = 0;
    b_req0 = 0; b_req1 = 0;
    b_addr0 = 0; b_addr1 = 0;
    b_data0 = 0; b_data1 = 0;

    // Reset and idle
    nxt(); nxt();
    rst = 1'b0;
    nxt(); settle();
    check("rst_busy", 32'(busy), 0);
    check("rst_lat_en", 32'(lat_en), 0);
    check("rst_lat_d", 32'(lat_d), 0);
    check("rst_grants", 32'({grant0, grant1, done0, done1}), 0);

    // Single write with data churn after the grant
    req0 = 1; addr0 = 2; data0 = 8'hA5;
    settle();
    check("w_grant0", 32'(grant0), 1);
    check("w_grant1", 32'(grant1), 0);
    for (int t = 1; t <= 5; t++) begin
      nxt();
      req0 = 0;
      data0 = 8'($urandom);
      addr0 = 2'($urandom);
      settle();
      exp_en = (t == 2 || t == 3) ? 4'b0100 : 4'b0000;
      check($sformatf("w_en_t%0d", t), 32'(lat_en), 32'(exp_en));
      check($sformatf("w_d_t%0d", t), 32'(lat_d), 32'h A5);
      check($sformatf("w_done_t%0d", t), 32'(done0), 32'(t == 4));
      check($sformatf("w_busy_t%0d", t), 32'(busy), 32'(t < 5));
      check($sformatf("w_g_t%0d", t), 32'(grant0), 0);
    end

    // Tie after reset: 0,1,0,1 at 5-cycle spacing
    do_reset();
    nxt();
    req0 = 1; req1 = 1; addr0 = 1; addr1 = 3;
    data0 = 8'h11; data1 = 8'h33;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) nxt();
      settle();
      w1 = ((t / 5) % 2) == 1;
      exp_en = 4'b0000;
      if (t % 5 == 2 || t % 5 == 3)
        exp_en = w1 ? 4'b1000 : 4'b0010;
      check($sformatf("tie_g0_t%0d", t), 32'(grant0),
            32'(t % 5 == 0 && !w1));
      check($sformatf("tie_g1_t%0d", t), 32'(grant1),
            32'(t % 5 == 0 && w1));
      check($sformatf("tie_en_t%0d", t), 32'(lat_en), 32'(exp_en));
      check($sformatf("tie_dn_t%0d", t), 32'({done0, done1}),
            (t % 5 == 4) ? (w1 ? 32'd1 : 32'd2) : 32'd0);
      if (t % 5 != 0)
        check($sformatf("tie_d_t%0d", t), 32'(lat_d),
              w1 ? 32'h33 : 32'h11);
    end
    req0 = 0; req1 = 0;

    // Late request from requester 1 during requester 0's write
    do_reset();
    nxt();
    req0 = 1; addr0 = 0;
    for (int t = 0; t < 9; t++) begin
      if (t > 0) nxt();
      if (t == 1) req0 = 0;
      if (t == 2) begin req1 = 1; addr1 = 3; end
      if (t == 6) req1 = 0;
      settle();
      exp_en = 4'b0000;
      if (t == 2 || t == 3) exp_en = 4'b0001;
      if (t == 7 || t == 8) exp_en = 4'b1000;
      check($sformatf("late_g1_t%0d", t), 32'(grant1), 32'(t == 5));
      check($sformatf("late_en_t%0d", t), 32'(lat_en), 32'(exp_en));
      if (t == 4)
        check("late_done0", 32'(done0), 1);
    end

    // Reset in the middle of the open window
    nxt(); nxt(); nxt();
    req0 = 1; addr0 = 2; data0 = 8'h5C;
    settle();
    check("mr_grant0", 32'(grant0), 1);
    nxt(); req0 = 0;
    nxt(); settle();
    check("mr_en_open", 32'(lat_en), 32'h4);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    settle();
    check("mr_en_after", 32'(lat_en), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done0), 0);
    req0 = 1; req1 = 1;
    settle();
    check("mr_tie_g0", 32'(grant0), 1);
    check("mr_tie_g1", 32'(grant1), 0);
    nxt(); req0 = 0; req1 = 0;
    settle();
    check("mr_no_done", 32'(done0), 0);
    for (int t = 0; t < 5; t++) nxt();

    // Longer setup/hold, single-cycle open, eight latches: T = 7
    b_req0 = 1; b_addr0 = 5; b_data0 = 8'h7E;
    for (int t = 0; t < 8; t++) begin
      if (t > 0) nxt();
      if (t == 1) b_data0 = 8'h00;
      settle();
      check($sformatf("sw_en_t%0d", t), 32'(b_lat_en),
            (t == 4) ? 32'h20 : 32'h0);
      check($sformatf("sw_g_t%0d", t), 32'(b_grant0),
            32'(t == 0 || t == 7));
      check($sformatf("sw_dn_t%0d", t), 32'(b_done0), 32'(t == 6));
      check($sformatf("sw_busy_t%0d", t), 32'(b_busy),
            32'(t >= 1 && t <= 6));
      if (t >= 1)
        check($sformatf("sw_d_t%0d", t), 32'(b_lat_d), 32'h7E);
    end
    b_req0 = 0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Enables must be at most one-hot on every cycle.
  always @(negedge clk) begin
    if (!$onehot0(lat_en)) begin
      failures++;
      $display("FAIL onehot_en: got %0h expected one-hot", lat_en);
    end
    if (!$onehot0(b_lat_en)) begin
      failures++;
      $display("FAIL onehot_sw: got %0h expected one-hot", b_lat_en);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
